// File: rtl/md_pkg.sv
// Purpose: shared MDOp encodings, FSM state encoding and counter sizing for e_muldiv.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional MADD/MSUB family is enabled by macro MD_MADD_EN.
package md_pkg;

    // MDOp encodings. Codes 7..10 only mean something when MD_MADD_EN is defined.
    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int MD_DIV_CYCLES_DEF = 10;
    localparam int MD_CNT_W_DEF      = $clog2(MD_DIV_CYCLES_DEF + 1);

    // Counter must hold the longest latency, which is the divide latency.
    function automatic int md_cnt_w(input int div_cycles);
        return $clog2(div_cycles + 1);
    endfunction

endpackage

// File: rtl/e_muldiv_if.sv
// Purpose: E-stage controller <-> multiply/divide unit signal bundle.
// Latency: n/a (wires only).
// Backpressure: Busy from the unit is the only stall indication; Start is ignored while Busy.
interface e_muldiv_if;
    logic        Start;
    logic        Cancel;
    logic [3:0]  MDOp;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic        ReadHi;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] LOHI_E;

    modport master (
        output Start, Cancel, MDOp, DataA, DataB, ReadHi,
        input  Busy, HI, LO, LOHI_E
    );

    modport slave (
        input  Start, Cancel, MDOp, DataA, DataB, ReadHi,
        output Busy, HI, LO, LOHI_E
    );
endinterface

// File: rtl/md_core.sv
// Purpose: combinational 64-bit mult/div (and, with MD_MADD_EN, multiply-accumulate) result.
// Latency: 0 cycles, pure combinational; the owner models the architectural latency.
// Backpressure: none.
module md_core
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MD_MADD_EN
    input  logic [31:0] hi,
    input  logic [31:0] lo,
`endif
    output logic [63:0] res,
    output logic        dbz
);
    logic [63:0] sa, sb, prod_s, prod_u;
    logic [31:0] mag_a, mag_b, div_s, div_u;
    logic [31:0] uq_s, ur_s, uq_u, ur_u, q_s, r_s;

    // Operand shaping, products and magnitude-based signed division.
    always_comb begin
        sa     = {{32{a[31]}}, a};
        sb     = {{32{b[31]}}, b};
        prod_s = sa * sb;
        prod_u = {32'd0, a} * {32'd0, b};
        mag_a  = a[31] ? (32'd0 - a) : a;
        mag_b  = b[31] ? (32'd0 - b) : b;
        // A zero divisor is replaced by 1 so the divider never sees zero; the result is discarded.
        div_s  = (b == 32'd0) ? 32'd1 : mag_b;
        div_u  = (b == 32'd0) ? 32'd1 : b;
        uq_s   = mag_a / div_s;
        ur_s   = mag_a % div_s;
        uq_u   = a / div_u;
        ur_u   = a % div_u;
        // -2^31 / -1 falls out naturally: magnitude 0x8000_0000 / 1, signs equal, remainder 0.
        q_s    = (a[31] ^ b[31]) ? (32'd0 - uq_s) : uq_s;
        r_s    = a[31] ? (32'd0 - ur_s) : ur_s;
        dbz    = (b == 32'd0);
    end

    // Result select by operation; {HI,LO} packing is {remainder, quotient} for divides.
    always_comb begin
        res = 64'd0;
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV:   res = {r_s, q_s};
            MD_DIVU:  res = {ur_u, uq_u};
`ifdef MD_MADD_EN
            MD_MADD:  res = {hi, lo} + prod_s;
            MD_MADDU: res = {hi, lo} + prod_u;
            MD_MSUB:  res = {hi, lo} - prod_s;
            MD_MSUBU: res = {hi, lo} - prod_u;
`endif
            default:  res = 64'd0;
        endcase
    end
endmodule

// File: rtl/e_muldiv.sv
// Purpose: E-stage multiply/divide unit owning HI/LO; optional MADD/MSUB via MD_MADD_EN.
// Latency: MULT_CYCLES (mult/madd) or DIV_CYCLES (div) Busy cycles; MTHI/MTLO write in one edge.
// Backpressure: Busy high while an op runs; Start while Busy or with Cancel is dropped.
module e_muldiv
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    e_muldiv_if.slave  md
);
    localparam int CNT_W = md_cnt_w(DIV_CYCLES);

    md_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] shadow_q, shadow_d;
    logic        dbz_q, dbz_d;
    logic [63:0] core_res;
    logic        core_dbz;
    logic        accept;

    md_core u_core (
        .op  (md.MDOp),
        .a   (md.DataA),
        .b   (md.DataB),
`ifdef MD_MADD_EN
        .hi  (hi_q),
        .lo  (lo_q),
`endif
        .res (core_res),
        .dbz (core_dbz)
    );

    assign accept    = md.Start && !md.Cancel && (state_q == IDLE);
    assign md.Busy   = (state_q == RUN);
    assign md.HI     = hi_q;
    assign md.LO     = lo_q;
    assign md.LOHI_E = md.ReadHi ? hi_q : lo_q;

    // Next-state: accept in IDLE, count down in RUN, commit shadow on the last busy cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        shadow_d = shadow_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (md.MDOp)
                        MD_MULT, MD_MULTU
`ifdef MD_MADD_EN
                        , MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU
`endif
                        : begin
                            state_d  = RUN;
                            cnt_d    = CNT_W'(MULT_CYCLES);
                            shadow_d = core_res;
                            dbz_d    = 1'b0;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d  = RUN;
                            cnt_d    = CNT_W'(DIV_CYCLES);
                            shadow_d = core_res;
                            dbz_d    = core_dbz;
                        end
                        MD_MTHI: hi_d = md.DataA;
                        MD_MTLO: lo_d = md.DataA;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    // Divide by zero burns the full latency but leaves HI/LO untouched.
                    if (!dbz_q) begin
                        hi_d = shadow_q[63:32];
                        lo_d = shadow_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            shadow_q <= 64'd0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            shadow_q <= shadow_d;
            dbz_q    <= dbz_d;
        end
    end
endmodule

// File: tb/tb_e_muldiv.sv
// Purpose: directed self-checking bench for e_muldiv with an expected-result scoreboard.
// Latency: checks MULT=5 / DIV=10 busy cycles.
// Backpressure: exercises Start while Busy and Start with Cancel.
module tb_e_muldiv;
    import md_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    e_muldiv_if md ();

    e_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; it is sampled at the following posedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cancel);
        md.Start  = 1'b1;
        md.Cancel = cancel;
        md.MDOp   = op;
        md.DataA  = a;
        md.DataB  = b;
        @(negedge clk);
        md.Start  = 1'b0;
        md.Cancel = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (md.Busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input logic [31:0] ehi, input logic [31:0] elo,
                          input string tag);
        exp_t e;
        int   n;
        sb_q.push_back({ehi, elo});
        issue(op, a, b, 1'b0);
        wait_done(n);
        chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
        e = sb_q.pop_front();
        chk({tag, "_hi"}, md.HI, e.hi);
        chk({tag, "_lo"}, md.LO, e.lo);
    endtask

    initial begin
        exp_t e;
        int   n;
        md.Start  = 1'b0;
        md.Cancel = 1'b0;
        md.MDOp   = 4'd0;
        md.DataA  = 32'd0;
        md.DataB  = 32'd0;
        md.ReadHi = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk("rst_busy", 32'(md.Busy), 32'd0);
        chk("rst_hi", md.HI, 32'd0);
        chk("rst_lo", md.LO, 32'd0);

        // Reset in the middle of a divide: result must never land.
        issue(MD_MTHI, 32'h0000_AAAA, 32'd0, 1'b0);
        chk("mthi_busy", 32'(md.Busy), 32'd0);
        chk("mthi_hi", md.HI, 32'h0000_AAAA);
        issue(MD_DIV, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        chk("div_busy_c4", 32'(md.Busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_busy", 32'(md.Busy), 32'd0);
        chk("midrst_hi", md.HI, 32'd0);
        chk("midrst_lo", md.LO, 32'd0);
        repeat (12) @(negedge clk);
        chk("midrst_late_hi", md.HI, 32'd0);
        chk("midrst_late_lo", md.LO, 32'd0);

        // Multiplies, back to back (next Start issued in the cycle Busy falls).
        run_op(MD_MULT,  32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000, "multu_2p32");

        // Divides.
        run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, "div_ovf");
        run_op(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC, "divu");

        // Divide by zero keeps HI/LO; Start while Busy is dropped.
        issue(MD_MTHI, 32'd5, 32'd0, 1'b0);
        issue(MD_MTLO, 32'd6, 32'd0, 1'b0);
        chk("set_hi5", md.HI, 32'd5);
        chk("set_lo6", md.LO, 32'd6);
        sb_q.push_back({32'd5, 32'd6});
        issue(MD_DIVU, 32'd9, 32'd0, 1'b0);
        issue(MD_MTHI, 32'h77, 32'd0, 1'b0);
        wait_done(n);
        chk("dbz_cycles", 32'(n + 1), 32'd10);
        e = sb_q.pop_front();
        chk("dbz_hi", md.HI, e.hi);
        chk("dbz_lo", md.LO, e.lo);

        // Cancel suppresses Start; LOHI_E mux.
        issue(MD_MULT, 32'd3, 32'd4, 1'b1);
        chk("cancel_busy", 32'(md.Busy), 32'd0);
        @(negedge clk);
        chk("cancel_hi", md.HI, 32'd5);
        chk("cancel_lo", md.LO, 32'd6);
        issue(MD_MTLO, 32'h1234, 32'd0, 1'b0);
        md.ReadHi = 1'b0;
        #1;
        chk("lohi_lo", md.LOHI_E, 32'h1234);
        md.ReadHi = 1'b1;
        #1;
        chk("lohi_hi", md.LOHI_E, 32'd5);
        @(negedge clk);

`ifdef MD_MADD_EN
        issue(MD_MTHI, 32'd0, 32'd0, 1'b0);
        issue(MD_MTLO, 32'd10, 32'd0, 1'b0);
        run_op(MD_MADD, 32'd3, 32'hFFFF_FFFC, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "madd");
        issue(MD_MTHI, 32'd0, 32'd0, 1'b0);
        issue(MD_MTLO, 32'd1, 32'd0, 1'b0);
        run_op(MD_MSUBU, 32'd2, 32'd1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "msubu_wrap");
`else
        issue(MD_MADD, 32'd3, 32'hFFFF_FFFC, 1'b0);
        chk("madd_off_busy", 32'(md.Busy), 32'd0);
        chk("madd_off_hi", md.HI, 32'd5);
        chk("madd_off_lo", md.LO, 32'h1234);
`endif
        issue(4'hF, 32'd3, 32'd4, 1'b0);
        chk("undef_busy", 32'(md.Busy), 32'd0);
        chk("undef_lohi", md.LOHI_E, md.ReadHi ? 32'(md.HI) : 32'(md.LO));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
